// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Mealy stall/flush controls for the 5-stage core,
// data-memory wait timeout FSM and stall/flush performance counters.
module hazard_ctrl #(
   parameter int TIMEOUT_CYCLES = 256,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             im_wait,
   input  logic             dm_wait,
   output logic             pc_stall,
   output logic             IF_ID_Hazard,
   output logic             IF_ID_flush,
   output logic             ID_EX_stall,
   output logic             ID_EX_flush,
   output logic             EX_MEM_stall,
   output logic             MEM_WB_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam int WC_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int WC_W   = (WC_RAW > 8) ? WC_RAW : 8;

   typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

   state_t          state, state_nxt;
   logic [WC_W-1:0] wait_cnt;
   logic            load_use;
   logic            flush_evt;

   assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= RUN;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:      if (dm_wait) state_nxt = MEM_WAIT;
         MEM_WAIT: begin
            if (!dm_wait)                                    state_nxt = RUN;
            else if (wait_cnt == WC_W'(TIMEOUT_CYCLES - 1)) state_nxt = ERROR;
         end
         ERROR:    state_nxt = ERROR;
         default:  state_nxt = RUN;
      endcase
   end

   // Controls are gated by rst so they drop the instant reset asserts.
   always_comb begin
      pc_stall     = 1'b0;
      IF_ID_Hazard = 1'b0;
      IF_ID_flush  = 1'b0;
      ID_EX_stall  = 1'b0;
      ID_EX_flush  = 1'b0;
      EX_MEM_stall = 1'b0;
      MEM_WB_flush = 1'b0;
      flush_evt    = 1'b0;
      if (rst) begin
         if (state == ERROR || dm_wait) begin
            pc_stall     = 1'b1;
            IF_ID_Hazard = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
         end else if (ex_branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_flush  = 1'b1;
            flush_evt    = 1'b1;
         end else if (load_use) begin
            pc_stall     = 1'b1;
            IF_ID_Hazard = 1'b1;
            ID_EX_flush  = 1'b1;
         end else if (im_wait) begin
            pc_stall     = 1'b1;
            IF_ID_flush  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
         stall_cnt   <= '0;
         flush_cnt   <= '0;
      end else begin
         case (state)
            RUN:      wait_cnt <= dm_wait ? WC_W'(1) : '0;
            MEM_WAIT: wait_cnt <= dm_wait ? wait_cnt + 1'b1 : '0;
            default:  wait_cnt <= wait_cnt;
         endcase
         if (state_nxt == ERROR) mem_timeout <= 1'b1;
         if (state != ERROR) begin
            if (pc_stall)  stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt) flush_cnt <= flush_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized bench for hazard_ctrl against a cycle-level reference model of the
// priority rules, run-length timeout and wrapping counters.
module tb_hazard_ctrl;
   localparam int T  = 4;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    id_rs1, id_rs2, ex_rd;
   logic          id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, im_wait, dm_wait;
   logic          pc_stall, IF_ID_Hazard, IF_ID_flush, ID_EX_stall, ID_EX_flush;
   logic          EX_MEM_stall, MEM_WB_flush, mem_timeout;
   logic [CW-1:0] stall_cnt, flush_cnt;

   hazard_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
      .im_wait(im_wait), .dm_wait(dm_wait),
      .pc_stall(pc_stall), .IF_ID_Hazard(IF_ID_Hazard), .IF_ID_flush(IF_ID_flush),
      .ID_EX_stall(ID_EX_stall), .ID_EX_flush(ID_EX_flush), .EX_MEM_stall(EX_MEM_stall),
      .MEM_WB_flush(MEM_WB_flush), .mem_timeout(mem_timeout),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Reference state: consecutive dm_wait run length, error flag, counters.
   int            m_run;
   bit            m_err;
   logic [CW-1:0] m_stall, m_flush;

   wire [6:0] ctrl = {pc_stall, IF_ID_Hazard, IF_ID_flush, ID_EX_stall,
                      ID_EX_flush, EX_MEM_stall, MEM_WB_flush};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic im, input logic dm);
      id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
      ex_rd = rd; ex_mem_read = mr; ex_branch_taken = br; im_wait = im; dm_wait = dm;
   endtask

   task automatic model_reset();
      m_run = 0; m_err = 0; m_stall = '0; m_flush = '0;
   endtask

   // One cycle: drive after negedge, check the Mealy outputs, advance the model.
   task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic mr,
                       input logic br, input logic im, input logic dm);
      logic [6:0] exp;
      bit lu;
      @(negedge clk);
      drive(rs1, rs2, u1, u2, rd, mr, br, im, dm);
      #1;
      lu = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
      if (m_err || dm) exp = 7'b1101011;
      else if (br)     exp = 7'b0010100;
      else if (lu)     exp = 7'b1100100;
      else if (im)     exp = 7'b1010000;
      else             exp = 7'b0000000;
      chk("ctrl", {57'd0, ctrl}, {57'd0, exp});
      chk("mem_timeout", {63'd0, mem_timeout}, {63'd0, m_err});
      chk("stall_cnt", {56'd0, stall_cnt}, {56'd0, m_stall});
      chk("flush_cnt", {56'd0, flush_cnt}, {56'd0, m_flush});
      if (!m_err) begin
         if (exp[6])     m_stall = m_stall + 1'b1;
         if (!dm && br)  m_flush = m_flush + 1'b1;
         m_run = dm ? m_run + 1 : 0;
         if (m_run >= T) m_err = 1;
      end
   endtask

   // Assert reset mid-cycle with busy inputs; everything must drop at once.
   task automatic do_reset();
      @(negedge clk);
      #2;
      drive(5'd3, 5'd3, 1'b1, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
      rst = 1'b0;
      #1;
      chk("rst_ctrl", {57'd0, ctrl}, 64'd0);
      chk("rst_timeout", {63'd0, mem_timeout}, 64'd0);
      chk("rst_cnts", {48'd0, stall_cnt, flush_cnt}, 64'd0);
      model_reset();
      @(negedge clk);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      model_reset();
      #1;
      chk("reset_ctrl", {57'd0, ctrl}, 64'd0);
      chk("reset_cnts", {47'd0, mem_timeout, stall_cnt, flush_cnt}, 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // load-use, single cycle
      step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("lu_stall_cnt", {56'd0, stall_cnt}, 64'd1);
      // load to x0
      step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      // rs2 load-use
      step(5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
      // branch with load-use
      step(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("br_flush_cnt", {56'd0, flush_cnt}, 64'd1);
      // dm_wait x3 with a pending branch, then release
      repeat (3) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      // timeout: 6 wait cycles then release
      do_reset();
      repeat (6) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      repeat (2) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("timeout_stall_cnt", {56'd0, stall_cnt}, 64'd4);
      // reset out of ERROR, then an instruction-fetch wait
      do_reset();
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);

      for (int i = 0; i < 3000; i++) begin
         if (m_err && $urandom_range(0, 7) == 0) do_reset();
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 4) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
